// File: rtl/load_extend_unit.sv
// Load-data stage: word-aligned memory read, lane select, sign/zero extension, valid/ready response.
// Optional misalignment trap is enabled with `define LOAD_MISALIGN_TRAP_EN.
module load_extend_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [15:0] cnt_q, cnt_d;
  logic        mem_re_q, mem_re_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic        f3_legal;
  logic        misalign;

  always_comb begin
    case (req_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
      default:                                f3_legal = 1'b0;
    endcase
  end

`ifdef LOAD_MISALIGN_TRAP_EN
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Upper bits take the lane MSB for signed loads (funct3[2]=0), zeros otherwise.
  function automatic logic [31:0] extend_lane(input logic [31:0] w,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   r = {{24{b[7] & ~f3[2]}}, b};
      2'b01:   r = {{16{h[15] & ~f3[2]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    f3_d        = f3_q;
    cnt_d       = cnt_q;
    mem_re_d    = mem_re_q;
    mem_addr_d  = mem_addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          off_d      = req_addr[1:0];
          f3_d       = req_funct3;
          mem_addr_d = {req_addr[31:2], 2'b00};
          if (!f3_legal || misalign) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = 32'd0;
            state_d     = S_RESP;
          end else begin
            mem_re_d = 1'b1;
            state_d  = S_READ;
          end
        end
      end
      S_READ: begin
        if (mem_ack) begin
          mem_re_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = extend_lane(mem_rdata, off_q, f3_q);
          cnt_d       = 16'd0;
          state_d     = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          // Any ack arriving after this point lands in RESP/IDLE and is dropped.
          mem_re_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = 32'd0;
          cnt_d       = 16'd0;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      off_q       <= 2'd0;
      f3_q        <= 3'd0;
      cnt_q       <= 16'd0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      cnt_q       <= cnt_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_extend_unit.sv
// Directed-vector bench for load_extend_unit; a second instance with TIMEOUT_CYCLES=4 covers the timeout path.
module tb_load_extend_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  logic        to_req_ready, to_mem_re, to_rsp_valid, to_rsp_err, to_busy;
  logic [31:0] to_mem_addr, to_rsp_data;

  int nchk  = 0;
  int npass = 0;

  always #5 clk = ~clk;

  load_extend_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_funct3(req_funct3),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
  );

  load_extend_unit #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(to_req_ready), .req_addr(req_addr), .req_funct3(req_funct3),
    .mem_re(to_mem_re), .mem_addr(to_mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(to_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(to_rsp_data), .rsp_err(to_rsp_err),
    .busy(to_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, acks on the ack_at-th mem_re cycle (0 = never),
  // then holds rsp_ready low for 'hold' cycles while a stray ack is driven.
  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] rdata,
                         input int ack_at, input int hold,
                         output logic [31:0] dat, output logic err, output logic [31:0] maddr,
                         output int re_cyc, output int lat, output logic stable, output logic rdy_leak);
    int n;
    re_cyc = 0; lat = 0; n = 0; stable = 1'b1; rdy_leak = 1'b0;
    req_valid = 1'b1; req_addr = addr; req_funct3 = f3; mem_rdata = rdata;
    step();
    req_valid = 1'b0; lat = 1;
    maddr = mem_addr;
    while (!rsp_valid && n < 300) begin
      if (req_ready) rdy_leak = 1'b1;
      if (mem_re) re_cyc++;
      mem_ack = mem_re && (re_cyc == ack_at);
      step();
      mem_ack = 1'b0; lat++; n++;
    end
    chk("rsp_valid_arrives", 32'(rsp_valid), 32'd1);
    dat = rsp_data; err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      if (req_ready) rdy_leak = 1'b1;
      mem_ack = 1'b1; mem_rdata = 32'h5A5A_A5A5;
      step();
      mem_ack = 1'b0;
      if (rsp_data !== dat || rsp_err !== err || rsp_valid !== 1'b1) stable = 1'b0;
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
  endtask

  logic [31:0] dat, maddr;
  logic        err, stable, leak;
  int          re_cyc, lat;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_funct3 = '0;
    mem_ack = 1'b0; mem_rdata = '0; rsp_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_outputs", {26'd0, mem_re, rsp_valid, rsp_err, busy, 2'b00}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);

    // LB sign-extends 0x80 from byte 3
    do_load(32'h0000_1003, 3'b000, 32'h80FF_1234, 1, 0, dat, err, maddr, re_cyc, lat, stable, leak);
    chk("lb_mem_addr", maddr, 32'h0000_1000);
    chk("lb_data", dat, 32'hFFFF_FF80);
    chk("lb_err", 32'(err), 32'd0);
    chk("lb_latency", 32'(lat), 32'd2);
    chk("lb_req_ready_idle", 32'(req_ready), 32'd1);

    do_load(32'h0000_2002, 3'b100, 32'h8001_7F00, 1, 0, dat, err, maddr, re_cyc, lat, stable, leak);
    chk("lbu_data", dat, 32'h0000_0001);
    do_load(32'h0000_2002, 3'b101, 32'h8001_7F00, 1, 0, dat, err, maddr, re_cyc, lat, stable, leak);
    chk("lhu_data", dat, 32'h0000_8001);
    do_load(32'h0000_2002, 3'b001, 32'h8001_7F00, 1, 0, dat, err, maddr, re_cyc, lat, stable, leak);
    chk("lh_data", dat, 32'hFFFF_8001);
    do_load(32'h0000_2001, 3'b000, 32'h8001_7F00, 1, 0, dat, err, maddr, re_cyc, lat, stable, leak);
    chk("lb_pos_data", dat, 32'h0000_007F);
    do_load(32'h0000_2000, 3'b001, 32'h8001_7F00, 1, 0, dat, err, maddr, re_cyc, lat, stable, leak);
    chk("lh_lo_data", dat, 32'h0000_7F00);

    // LW with late ack and slow writeback; stray acks in RESP must not disturb the result
    do_load(32'h0000_3000, 3'b010, 32'h8001_7F00, 5, 3, dat, err, maddr, re_cyc, lat, stable, leak);
    chk("lw_re_cycles", 32'(re_cyc), 32'd5);
    chk("lw_data", dat, 32'h8001_7F00);
    chk("lw_err", 32'(err), 32'd0);
    chk("lw_hold_stable", 32'(stable), 32'd1);
    chk("lw_req_ready_low", 32'(leak), 32'd0);

    do_load(32'h0000_3000, 3'b011, 32'hFFFF_FFFF, 1, 1, dat, err, maddr, re_cyc, lat, stable, leak);
    chk("ill011_re", 32'(re_cyc), 32'd0);
    chk("ill011_err", 32'(err), 32'd1);
    chk("ill011_data", dat, 32'd0);
    do_load(32'h0000_3000, 3'b111, 32'hFFFF_FFFF, 1, 0, dat, err, maddr, re_cyc, lat, stable, leak);
    chk("ill111_err_re", {31'd0, err} | 32'(re_cyc << 1), 32'd1);

    // Timeout on the 4-cycle instance; the default instance just sits in READ
    reset = 1'b1; step(); reset = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0000_5000; req_funct3 = 3'b010; mem_rdata = 32'h1234_5678;
    step();
    req_valid = 1'b0;
    re_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      if (to_mem_re) re_cyc++;
      chk("to_no_rsp_yet", 32'(to_rsp_valid), 32'd0);
      step();
    end
    chk("to_re_cycles", 32'(re_cyc), 32'd4);
    chk("to_rsp_valid", 32'(to_rsp_valid), 32'd1);
    chk("to_rsp_err", 32'(to_rsp_err), 32'd1);
    chk("to_mem_re_off", 32'(to_mem_re), 32'd0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("to_late_ack_err", 32'(to_rsp_err), 32'd1);
    chk("to_late_ack_data", to_rsp_data, 32'd0);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    chk("to_back_idle", 32'(to_req_ready), 32'd1);

    // Reset in READ together with an ack discards the ack
    req_valid = 1'b1; req_addr = 32'h0000_6000; req_funct3 = 3'b010; mem_rdata = 32'hDEAD_BEEF;
    step();
    req_valid = 1'b0;
    step();
    chk("mid_read_re", 32'(mem_re), 32'd1);
    reset = 1'b1; mem_ack = 1'b1;
    step();
    reset = 1'b0; mem_ack = 1'b0;
    chk("rst_mid_outputs", {26'd0, mem_re, rsp_valid, rsp_err, busy, 2'b00}, 32'd0);
    chk("rst_mid_addr_data", mem_addr | rsp_data, 32'd0);
    chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
    step();
    chk("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);

    do_load(32'h0000_4001, 3'b010, 32'hCAFE_BABE, 1, 0, dat, err, maddr, re_cyc, lat, stable, leak);
`ifdef LOAD_MISALIGN_TRAP_EN
    chk("mis_lw_err", 32'(err), 32'd1);
    chk("mis_lw_re", 32'(re_cyc), 32'd0);
    chk("mis_lw_data", dat, 32'd0);
`else
    chk("mis_lw_err", 32'(err), 32'd0);
    chk("mis_lw_addr", maddr, 32'h0000_4000);
    chk("mis_lw_data", dat, 32'hCAFE_BABE);
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/load_extend_unit.md
Name: load_extend_unit

Overview:
- Load-data stage between the data-memory read port and the writeback mux.
- Accepts one load request from execute (address + funct3) and issues a word-aligned memory read.
- Waits for the memory acknowledge, selects the byte/halfword lane, then sign- or zero-extends it to 32 bits.
- Returns the result to writeback over a valid/ready handshake. One load in flight at a time.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in READ without mem_ack before an error response is returned. Range 1..65535.

Ports:
- clk  in  1  : system clock, rising edge.
- reset  in  1  : synchronous, active-high reset.
- req_valid  in  1  : load request present.
- req_ready  out  1  : unit can accept a request (high only in IDLE).
- req_addr  in  32  : byte address of the load.
- req_funct3  in  3  : 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal.
- mem_re  out  1  : memory read strobe.
- mem_addr  out  32  : word-aligned read address, {addr[31:2], 2'b00}.
- mem_ack  in  1  : read data valid this cycle.
- mem_rdata  in  32  : read word.
- rsp_valid  out  1  : result available.
- rsp_ready  in  1  : writeback consumes the result.
- rsp_data  out  32  : extended load result.
- rsp_err  out  1  : illegal funct3, timeout, or misaligned access (when the trap feature is enabled).
- busy  out  1  : state != IDLE.

Behaviour:
- Reset values: req_ready=1 (state IDLE); mem_re=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0; timeout counter=0. All outputs are registered except req_ready and busy, which decode directly from the state.
- FSM states: IDLE, READ, RESP.
- IDLE:
  - A request is accepted on the edge where req_valid && req_ready.
  - On accept, latch addr[1:0] and funct3, and register mem_addr.
  - Illegal funct3 -> RESP with rsp_err=1, rsp_data=0, and mem_re never asserted.
  - Otherwise -> READ with mem_re=1.
- READ:
  - mem_re and mem_addr stay stable until mem_ack is sampled high.
  - On mem_ack: mem_re drops on the same edge; rsp_data is loaded with the extended lane, rsp_err=0, rsp_valid=1; go to RESP.
  - The counter increments each READ cycle without ack. When the count reaches TIMEOUT_CYCLES: mem_re=0, rsp_err=1, rsp_data=0, go to RESP.
  - The counter clears on leaving READ.
- RESP:
  - rsp_valid, rsp_data and rsp_err are held until rsp_ready is sampled high.
  - On that edge: rsp_valid=0, return to IDLE.
  - A new request is accepted no earlier than the following cycle (no bypass).
- Latency: with an ack on the first READ cycle, rsp_valid rises 2 cycles after the accept edge. Throughput is at most one load per 3 cycles.
- Lane select:
  - Byte loads: rdata[8*addr[1:0] +: 8].
  - Halfword loads: addr[1] ? rdata[31:16] : rdata[15:0].
  - Word loads: rdata.
- Extension: funct3[2]=0 replicates the lane MSB into the upper bits; funct3[2]=1 fills the upper bits with zeros.
- mem_ack sampled in IDLE or RESP is ignored.
- A late ack arriving after a timeout is ignored.
- Reset in any state returns to IDLE on the next edge with all outputs at reset values; any pending ack is discarded.

Optional Feature:
- Macro: LOAD_MISALIGN_TRAP_EN.
- Defined: a misaligned request is detected in IDLE and goes directly to RESP with rsp_err=1, rsp_data=0, and no memory access. Misaligned means LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
- Undefined: the offending low address bits are ignored. Halfword loads select the half by addr[1] only; LW always returns the full word. rsp_err is never set for misalignment.

Test Plan:
- LB at addr 0x1003, mem_rdata=0x80FF_1234, ack first READ cycle -> mem_addr=0x1000; rsp_data=0xFFFF_FF80, rsp_err=0, rsp_valid 2 cycles after accept.
- LBU then LHU at addr 0x2002, mem_rdata=0x8001_7F00 -> rsp_data=0x0000_0001, then 0x0000_8001; LH at the same address -> 0xFFFF_8001.
- LW at 0x3000, ack after 5 cycles, rsp_ready held low 3 cycles -> mem_re high exactly 5 cycles; rsp_data=0x8001_7F00 held stable until rsp_ready; req_ready=0 throughout.
- funct3=011 -> no mem_re pulse; rsp_err=1, rsp_data=0. Separately, with TIMEOUT_CYCLES=4 and no ack -> rsp_err=1 after 4 READ cycles; a later ack is ignored.
- Reset asserted mid-READ, then ack asserted -> next cycle all outputs zero, req_ready=1, no rsp_valid.
- LW at 0x4001: with LOAD_MISALIGN_TRAP_EN, rsp_err=1 and no mem_re; without it, mem_addr=0x4000 and the full word is returned with rsp_err=0.
